// File: rtl/dl_sync_deadlock_monitor_if.sv
// Signal bundle between an hls4ml dataflow region (master) and its deadlock monitor (slave).
interface dl_sync_deadlock_monitor_if #(
  parameter int N_PROC = 15,
  parameter int CW     = 32
);
  // No valid/ready handshake: region signals are sampled as levels on every dl_clock edge;
  // monitor outputs are levels, except token_clear, which is a one-cycle strobe.
  logic              all_finish;
  logic [N_PROC-1:0] proc_done;
  logic [N_PROC-1:0] proc_continue;
  logic [N_PROC-1:0] proc_chan_blk;
  logic [N_PROC-1:0] blocked_vec;
  logic              dl_detect_out;
  logic [N_PROC-1:0] origin;
  logic              token_clear;
  logic [CW-1:0]     dl_cycle;

  modport master (
    output all_finish, proc_done, proc_continue, proc_chan_blk,
    input  blocked_vec, dl_detect_out, origin, token_clear, dl_cycle
  );

  modport slave (
    input  all_finish, proc_done, proc_continue, proc_chan_blk,
    output blocked_vec, dl_detect_out, origin, token_clear, dl_cycle
  );
endinterface

// File: rtl/dl_sync_deadlock_monitor.sv
// Deadlock monitor for a dataflow region: flags a blocked set that stays unchanged for THRESH cycles.
// Optional macro DL_CYCLE_STAMP_EN adds a saturating cycle counter latched into dl_cycle on detection.
module dl_sync_deadlock_monitor #(
  parameter int                N_PROC    = 15,
  parameter logic [N_PROC-1:0] SYNC_MASK = 15'h6000,
  parameter int                THRESH    = 16,
  parameter int                CW        = 32
) (
  input  logic                       dl_clock,
  input  logic                       dl_reset,
  dl_sync_deadlock_monitor_if.slave  mon,
  output logic [1:0]                 dbg_state
);

  localparam int                CNTW     = $clog2(THRESH + 1);
  localparam logic [CNTW-1:0]   THRESH_C = CNTW'(THRESH);
  localparam logic [CNTW-1:0]   CNT_ONE  = CNTW'(1);
  localparam logic [N_PROC-1:0] VEC_ONE  = N_PROC'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    DETECT = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [N_PROC-1:0] done_reg;
  logic [N_PROC-1:0] snap, snap_nxt;
  logic [N_PROC-1:0] origin_q, origin_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic              detect_q, detect_nxt;
  logic              tc_q, tc_nxt;
  logic              grp_done;
  logic [N_PROC-1:0] sync_blk;
  logic [N_PROC-1:0] raw_blk;
  logic              active;

  // A group member is sync-blocked when it has held ap_done for more than one cycle
  // without ap_continue while some other group member is not yet done.
  assign grp_done = &(mon.proc_done | ~SYNC_MASK);
  assign sync_blk = SYNC_MASK & done_reg & mon.proc_done & {N_PROC{~grp_done}};
  assign raw_blk  = sync_blk | mon.proc_chan_blk;
  assign active   = (|raw_blk) & ~mon.all_finish;

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      state    <= IDLE;
      done_reg <= '0;
      snap     <= '0;
      cnt      <= '0;
      detect_q <= 1'b0;
      origin_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      done_reg <= mon.proc_done & ~mon.proc_continue;
      snap     <= snap_nxt;
      cnt      <= cnt_nxt;
      detect_q <= detect_nxt;
      origin_q <= origin_nxt;
      tc_q     <= tc_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    snap_nxt   = snap;
    cnt_nxt    = cnt;
    detect_nxt = detect_q;
    origin_nxt = origin_q;
    tc_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (active) begin
          snap_nxt  = raw_blk;
          cnt_nxt   = CNT_ONE;
          state_nxt = WATCH;
        end else begin
          cnt_nxt = '0;
        end
      end
      WATCH: begin
        if (mon.all_finish || (raw_blk == '0)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (raw_blk != snap) begin
          snap_nxt = raw_blk;
          cnt_nxt  = CNT_ONE;
        end else if (cnt == THRESH_C) begin
          state_nxt  = DETECT;
          detect_nxt = 1'b1;
          // Two's-complement trick isolates the lowest set bit.
          origin_nxt = snap & (~snap + VEC_ONE);
          tc_nxt     = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DETECT: begin
        if (mon.all_finish) begin
          state_nxt  = IDLE;
          detect_nxt = 1'b0;
          origin_nxt = '0;
          cnt_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign mon.blocked_vec   = (state == DETECT) ? snap : raw_blk;
  assign mon.dl_detect_out = detect_q;
  assign mon.origin        = origin_q;
  assign mon.token_clear   = tc_q;
  assign dbg_state         = state;

`ifdef DL_CYCLE_STAMP_EN
  logic [CW-1:0] cyc;
  logic [CW-1:0] stamp;
  logic          enter_detect;

  assign enter_detect = (state == WATCH) && (state_nxt == DETECT);

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      cyc   <= '0;
      stamp <= '0;
    end else begin
      if (cyc != '1) cyc <= cyc + CW'(1);
      if (enter_detect) stamp <= cyc;
    end
  end

  assign mon.dl_cycle = stamp;
`else
  assign mon.dl_cycle = '0;
`endif

endmodule

// File: doc/dl_sync_deadlock_monitor.md
Name: dl_sync_deadlock_monitor

Overview:
- Parametrised simulation-side deadlock monitor for hls4ml dataflow regions of N_PROC processes.
- Tracks per-process ap_done/ap_continue output-sync blocking across a configurable sync group, plus externally supplied FIFO/PIPO block flags.
- Declares deadlock when a non-empty blocked set persists unchanged for THRESH cycles.
- Reports a one-hot origin and a token_clear pulse, in the same style as the existing dataflow deadlock detector/report units.

Parameters:
- N_PROC, 15, number of monitored dataflow processes.
- SYNC_MASK, 15'h6000, bit i = 1 puts process i in the output-sync group.
- THRESH, 16, consecutive stable-blocked cycles needed to declare deadlock (≥1).
- CW, 32, width of the optional cycle stamp.

Ports:
- dl_clock  in  1  monitor clock.
- dl_reset  in  1  asynchronous, active-low reset.
- all_finish  in  1  design finished; masks detection and releases DETECT.
- proc_done  in  N_PROC  live ap_done of each process.
- proc_continue  in  N_PROC  live ap_continue of each process.
- proc_chan_blk  in  N_PROC  OR of FIFO/PIPO/start/TLF/input-sync block flags per process.
- blocked_vec  out  N_PROC  current combinational blocked set (frozen during DETECT).
- dl_detect_out  out  1  deadlock declared (level).
- origin  out  N_PROC  one-hot lowest-index blocked process at detection.
- token_clear  out  1  single-cycle pulse on detection.
- dl_cycle  out  CW  cycle stamp of detection (optional feature).

Behaviour:
- Done register: done_reg[i] <= proc_done[i] & ~proc_continue[i]; reset 0.
- Group done: grp_done = &(proc_done | ~SYNC_MASK).
- Sync block: sync_blk[i] = SYNC_MASK[i] & done_reg[i] & proc_done[i] & ~grp_done.
- Raw block: raw_blk[i] = sync_blk[i] | proc_chan_blk[i].
- blocked_vec = raw_blk while state != DETECT; in DETECT it holds the registered snapshot.
- active = (|raw_blk) & ~all_finish.
- Registers: state, snap[N_PROC], cnt[$clog2(THRESH+1)].
- IDLE:
  - active: snap <= raw_blk, cnt <= 1, go to WATCH.
  - otherwise: cnt <= 0.
- WATCH, evaluated per edge in priority order:
  1. all_finish or raw_blk == 0: go to IDLE, cnt <= 0.
  2. raw_blk != snap: snap <= raw_blk, cnt <= 1 (restart).
  3. cnt == THRESH: go to DETECT; dl_detect_out <= 1; origin <= lowest set bit of snap; token_clear <= 1.
  4. otherwise: cnt <= cnt + 1.
- Detection latency: blocked set sampled identical at edges E1..E_THRESH means dl_detect_out is high after edge E_(THRESH+1). With THRESH=1, detection follows the 2nd edge.
- DETECT:
  - token_clear drops after exactly one cycle.
  - dl_detect_out, origin and snap held regardless of raw_blk changes.
  - all_finish: next edge to IDLE, dl_detect_out <= 0, origin <= 0.
- Simultaneous all_finish and cnt == THRESH in WATCH: all_finish wins, no detection.
- cnt never exceeds THRESH. No wrap.
- Reset (any time, including mid-WATCH/DETECT): immediately state = IDLE; dl_detect_out, origin, token_clear, snap, cnt, done_reg, dl_cycle all 0.
- Processes with SYNC_MASK = 0 contribute only via proc_chan_blk.

Optional Feature:
- DL_CYCLE_STAMP_EN defined:
  - A CW-bit free-running counter starts at 0 after reset and saturates at all-ones.
  - Its value is latched into dl_cycle on the edge entering DETECT and held until reset.
  - Returning to IDLE does not clear dl_cycle. A later detection overwrites it.
- Not defined: dl_cycle tied to 0, no counter logic.

Test Plan:
- Reset then idle: all inputs 0 for 50 cycles -> dl_detect_out=0, origin=0, token_clear never pulses.
- N_PROC=15, SYNC_MASK=15'h6000, THRESH=4: proc 13 done & ~continue held, proc 14 done=0 -> blocked_vec=15'h2000; dl_detect_out rises after 5th edge following first blocked sample; origin=15'h2000; token_clear high exactly 1 cycle.
- Same setup, proc_chan_blk[2] toggles at cycle 3 -> counter restarts; detection 5 edges after last change; origin=15'h0004 while bit 2 set.
- Blocked for 3 cycles, then proc 14 asserts done (grp_done=1) -> IDLE, no detection.
- In DETECT, assert all_finish -> next edge dl_detect_out=0, origin=0; all_finish coincident with cnt==THRESH -> no detection.
- With DL_CYCLE_STAMP_EN: detection entered at cycle 37 after reset -> dl_cycle=37; async reset asserted mid-WATCH -> all outputs 0 immediately.
